conflict_scan: RTL and testbench
================================

Name: conflict_scan

Overview:
- Sequential, parametrised collision checker for the Tetris playfield; next generation of the 10x10 / 3x3 single-cycle overlap check.
- Adds configurable field and piece dimensions, signed piece position, wall/floor detection and a valid/ready request/result handshake.
- Scans one piece row per clock, so a large field needs no wide single-cycle AND tree.
- Sits between the piece-movement controller (proposes a move/rotation) and the game FSM (commits or rejects it).

Parameters:
- FIELD_W, 10, playfield columns.
- FIELD_H, 10, playfield rows.
- BLK, 3, piece bounding box edge (BLK x BLK cells); legal range 2..4.
- POS_W, 5, width of the signed two's-complement piece coordinates.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- field  input  FIELD_W*FIELD_H  occupancy; ascending range [0:N-1]; cell (x,y) at bit y*FIELD_W+x; 1 = occupied.
- block  input  BLK*BLK  piece mask; ascending range; cell (i,j) at bit j*BLK+i.
- blk_x  input  POS_W  signed column of the piece's top-left cell.
- blk_y  input  POS_W  signed row of the piece's top-left cell; row 0 is the top.
- res_valid  output  1  result available.
- res_ready  input  1  consumer takes the result.
- res_hit  output  1  a piece cell overlaps an occupied field cell.
- res_wall  output  1  a piece cell is at x<0, x>=FIELD_W or y>=FIELD_H.
- res_conflict  output  1  res_hit | res_wall.

Behaviour:
- Reset (asynchronous, active-low): state IDLE; req_ready=1; res_valid=0; res_hit=0; res_wall=0; res_conflict=0; row counter=0.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - req_ready=1.
  - On a clock edge with req_valid=1, capture field, block, blk_x and blk_y into internal registers.
  - Clear the hit and wall accumulators, set row=0, go to SCAN.
- SCAN:
  - req_ready=0.
  - Each cycle, evaluate piece row j=row for every i in 0..BLK-1 where block[j*BLK+i]=1.
  - Compute cx=blk_x+i and cy=blk_y+j with POS_W+1-bit signed arithmetic, so there is no overflow.
  - If cx<0, cx>=FIELD_W or cy>=FIELD_H, OR 1 into the wall accumulator.
  - Else if cy>=0 and field[cy*FIELD_W+cx]=1, OR 1 into the hit accumulator.
  - Cells with cy<0 (above the top, spawn area) and 0<=cx<FIELD_W never conflict.
  - After row BLK-1, go to DONE. No early exit: latency is fixed.
- DONE:
  - res_valid=1. res_hit, res_wall and res_conflict show the registered accumulators and stay stable while res_valid=1.
  - On an edge with res_ready=1, go to IDLE: res_valid=0 and the res_* flags clear to 0.
- Latency: if the request is accepted on edge T, res_valid is 1 after edge T+BLK. Minimum request-to-request spacing is BLK+2 cycles when res_ready is tied high.
- Captured inputs: after acceptance, changes on field, block, blk_x and blk_y have no effect on the result in flight.
- req_valid outside IDLE is ignored and not queued. The requester must hold req_valid until it sees req_ready.
- An all-zero block mask gives res_hit=res_wall=0 after the normal latency.
- Reset mid-SCAN or mid-DONE aborts immediately with no result. The next request after release starts clean.

Optional Feature:
- Macro: CONFLICT_SCAN_COUNT_EN.
- Defined:
  - Extra output res_count, width $clog2(BLK*BLK+1).
  - It counts piece cells that are either a hit or a wall cell; each cell is counted at most once.
  - Resets to 0, is valid with res_valid, and clears on result handshake.
  - Used by the AI/scoring path to rank placements.
- Undefined: the port and its adder logic are absent; all other behaviour is identical.

Decomposition:
- Package conflict_scan_pkg holds:
  - state encoding typedef (IDLE=2'd0, SCAN=2'd1, DONE=2'd2);
  - default field/piece dimension constants;
  - a function for the cell index, y*FIELD_W+x.
- One sub-module, conflict_scan_row: combinational evaluation of one piece row. It returns row hit, row wall and, with CONFLICT_SCAN_COUNT_EN, row count. The parent holds the FSM, capture registers and accumulators.

Test Plan:
- Empty field; T-piece mask 9'b111_010_000; blk_x=3, blk_y=0 -> res_valid three cycles after acceptance; hit=0, wall=0, conflict=0.
- Field with bit 24 set (x=4, y=2); same piece at blk_x=3, blk_y=1 -> hit=1, wall=0, conflict=1; count=1 when enabled.
- Empty field; mask 9'b100_100_100 at blk_x=-1 -> wall=1. Same mask 9'b001_001_001 at blk_x=8 -> wall=1 (cx=10).
- Piece at blk_y=-2 with only its bottom row inside the field, on an empty field -> conflict=0. Same piece at blk_y=8 -> wall=1 (floor).
- Handshake: hold res_ready=0 for 5 cycles and change the field and piece inputs -> result stable; req_ready=0 throughout; the pulse on req_valid is not accepted.
- Assert rst_n=0 during SCAN (row=1) -> all outputs 0 and req_ready=1 after release; the next request returns the correct result.

Source files
------------

// File: rtl/conflict_scan_pkg.sv
// Shared types and constants for the sequential playfield collision checker.
// Optional build macro: CONFLICT_SCAN_COUNT_EN (adds the conflicting-cell count).
package conflict_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FIELD_W_DEF = 10;
  localparam int FIELD_H_DEF = 10;
  localparam int BLK_DEF     = 3;
  localparam int POS_W_DEF   = 5;

  function automatic int cell_idx(input int x, input int y, input int w);
    return y * w + x;
  endfunction

endpackage

// File: rtl/conflict_scan_row.sv
// Combinational evaluation of one piece row against the playfield and walls.
// With CONFLICT_SCAN_COUNT_EN it also returns how many row cells conflict.
module conflict_scan_row
  import conflict_scan_pkg::*;
#(
  parameter int FIELD_W = FIELD_W_DEF,
  parameter int FIELD_H = FIELD_H_DEF,
  parameter int BLK     = BLK_DEF,
  parameter int POS_W   = POS_W_DEF,
  parameter int CNT_W   = $clog2(BLK*BLK+1)
) (
  input  logic [0:FIELD_W*FIELD_H-1] i_field,
  input  logic [0:BLK-1]             i_mask,
  input  logic signed [POS_W-1:0]    i_blk_x,
  input  logic signed [POS_W:0]      i_cy,
`ifdef CONFLICT_SCAN_COUNT_EN
  output logic [CNT_W-1:0]           o_count,
`endif
  output logic                       o_hit,
  output logic                       o_wall
);

  localparam int IDX_W = $clog2(FIELD_W*FIELD_H);

  int   w_cx;
  int   w_cy;
  logic w_cell_wall;
  logic w_cell_hit;

  always_comb begin
    o_hit       = 1'b0;
    o_wall      = 1'b0;
    w_cx        = 0;
    w_cy        = int'(i_cy);
    w_cell_wall = 1'b0;
    w_cell_hit  = 1'b0;
`ifdef CONFLICT_SCAN_COUNT_EN
    o_count     = '0;
`endif
    for (int i = 0; i < BLK; i++) begin
      w_cx        = int'(i_blk_x) + i;
      w_cell_wall = (w_cx < 0) || (w_cx >= FIELD_W) || (w_cy >= FIELD_H);
      // Cells above the top row (spawn area) are neither wall nor hit.
      w_cell_hit  = !w_cell_wall && (w_cy >= 0) &&
                    i_field[IDX_W'(cell_idx(w_cx, w_cy, FIELD_W))];
      if (i_mask[i] && w_cell_wall) o_wall = 1'b1;
      if (i_mask[i] && w_cell_hit)  o_hit  = 1'b1;
`ifdef CONFLICT_SCAN_COUNT_EN
      if (i_mask[i] && (w_cell_wall || w_cell_hit)) o_count = o_count + CNT_W'(1);
`endif
    end
  end

endmodule

// File: rtl/conflict_scan.sv
// Sequential Tetris collision checker: captures a request, scans one piece row
// per clock, then holds the result until taken. Optional: CONFLICT_SCAN_COUNT_EN.
module conflict_scan
  import conflict_scan_pkg::*;
#(
  parameter int FIELD_W = FIELD_W_DEF,
  parameter int FIELD_H = FIELD_H_DEF,
  parameter int BLK     = BLK_DEF,
  parameter int POS_W   = POS_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_req_valid,
  output logic                         o_req_ready,
  input  logic [0:FIELD_W*FIELD_H-1]   i_field,
  input  logic [0:BLK*BLK-1]           i_block,
  input  logic signed [POS_W-1:0]      i_blk_x,
  input  logic signed [POS_W-1:0]      i_blk_y,
  output logic                         o_res_valid,
  input  logic                         i_res_ready,
`ifdef CONFLICT_SCAN_COUNT_EN
  output logic [$clog2(BLK*BLK+1)-1:0] o_res_count,
`endif
  output logic                         o_res_hit,
  output logic                         o_res_wall,
  output logic                         o_res_conflict
);

  localparam int RW    = $clog2(BLK);
  localparam int CNT_W = $clog2(BLK*BLK+1);

  state_t                     r_state;
  logic [RW-1:0]              r_row;
  logic [0:FIELD_W*FIELD_H-1] r_field;
  logic [0:BLK*BLK-1]         r_block;
  logic signed [POS_W-1:0]    r_blk_x;
  logic signed [POS_W-1:0]    r_blk_y;
  logic                       r_hit;
  logic                       r_wall;

  logic [0:BLK-1]             w_mask;
  logic signed [POS_W:0]      w_cy;
  logic                       w_hit;
  logic                       w_wall;

  always_comb begin
    w_mask = '0;
    for (int j = 0; j < BLK; j++)
      if (r_row == RW'(j))
        for (int i = 0; i < BLK; i++) w_mask[i] = r_block[j*BLK+i];
  end

  // One extra bit keeps blk_y + row free of overflow.
  assign w_cy = {r_blk_y[POS_W-1], r_blk_y} + (POS_W+1)'(r_row);

`ifdef CONFLICT_SCAN_COUNT_EN
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] r_cnt;
`endif

  conflict_scan_row #(
    .FIELD_W (FIELD_W),
    .FIELD_H (FIELD_H),
    .BLK     (BLK),
    .POS_W   (POS_W),
    .CNT_W   (CNT_W)
  ) u_row (
    .i_field (r_field),
    .i_mask  (w_mask),
    .i_blk_x (r_blk_x),
    .i_cy    (w_cy),
`ifdef CONFLICT_SCAN_COUNT_EN
    .o_count (w_count),
`endif
    .o_hit   (w_hit),
    .o_wall  (w_wall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_row          <= '0;
      r_field        <= '0;
      r_block        <= '0;
      r_blk_x        <= '0;
      r_blk_y        <= '0;
      r_hit          <= 1'b0;
      r_wall         <= 1'b0;
      o_req_ready    <= 1'b1;
      o_res_valid    <= 1'b0;
      o_res_hit      <= 1'b0;
      o_res_wall     <= 1'b0;
      o_res_conflict <= 1'b0;
`ifdef CONFLICT_SCAN_COUNT_EN
      r_cnt          <= '0;
      o_res_count    <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (i_req_valid) begin
          r_field     <= i_field;
          r_block     <= i_block;
          r_blk_x     <= i_blk_x;
          r_blk_y     <= i_blk_y;
          r_hit       <= 1'b0;
          r_wall      <= 1'b0;
          r_row       <= '0;
          o_req_ready <= 1'b0;
          r_state     <= SCAN;
`ifdef CONFLICT_SCAN_COUNT_EN
          r_cnt       <= '0;
`endif
        end
        SCAN: begin
          r_hit  <= r_hit  | w_hit;
          r_wall <= r_wall | w_wall;
`ifdef CONFLICT_SCAN_COUNT_EN
          r_cnt  <= r_cnt + w_count;
`endif
          if (r_row == RW'(BLK-1)) begin
            // Publish the final row together with the accumulated rows.
            o_res_valid    <= 1'b1;
            o_res_hit      <= r_hit | w_hit;
            o_res_wall     <= r_wall | w_wall;
            o_res_conflict <= r_hit | w_hit | r_wall | w_wall;
`ifdef CONFLICT_SCAN_COUNT_EN
            o_res_count    <= r_cnt + w_count;
`endif
            r_state        <= DONE;
          end else begin
            r_row <= r_row + RW'(1);
          end
        end
        DONE: if (i_res_ready) begin
          o_res_valid    <= 1'b0;
          o_res_hit      <= 1'b0;
          o_res_wall     <= 1'b0;
          o_res_conflict <= 1'b0;
`ifdef CONFLICT_SCAN_COUNT_EN
          o_res_count    <= '0;
`endif
          o_req_ready    <= 1'b1;
          r_state        <= IDLE;
        end
        default: begin
          r_state     <= IDLE;
          o_req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conflict_scan.sv
// Randomized self-checking bench for conflict_scan against a cell-by-cell model.
module tb_conflict_scan;

  localparam int FW = 10;
  localparam int FH = 10;
  localparam int B  = 3;
  localparam int PW = 5;
  localparam int CW = $clog2(B*B+1);

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 req_valid;
  logic                 req_ready;
  logic [0:FW*FH-1]     field;
  logic [0:B*B-1]       block;
  logic signed [PW-1:0] blk_x;
  logic signed [PW-1:0] blk_y;
  logic                 res_valid;
  logic                 res_ready;
  logic                 res_hit;
  logic                 res_wall;
  logic                 res_conflict;
`ifdef CONFLICT_SCAN_COUNT_EN
  logic [CW-1:0]        res_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  conflict_scan #(.FIELD_W(FW), .FIELD_H(FH), .BLK(B), .POS_W(PW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_field        (field),
    .i_block        (block),
    .i_blk_x        (blk_x),
    .i_blk_y        (blk_y),
    .o_res_valid    (res_valid),
    .i_res_ready    (res_ready),
`ifdef CONFLICT_SCAN_COUNT_EN
    .o_res_count    (res_count),
`endif
    .o_res_hit      (res_hit),
    .o_res_wall     (res_wall),
    .o_res_conflict (res_conflict)
  );

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Walk every set piece cell and classify it directly from the game rules.
  function automatic void model(input logic [0:FW*FH-1] f, input logic [0:B*B-1] b,
                                input int x, input int y,
                                output int hit, output int wall, output int cnt);
    hit = 0; wall = 0; cnt = 0;
    for (int j = 0; j < B; j++)
      for (int i = 0; i < B; i++)
        if (b[j*B+i]) begin
          int cx, cy;
          cx = x + i;
          cy = y + j;
          if (cx < 0 || cx >= FW || cy >= FH) begin
            wall = 1; cnt++;
          end else if (cy >= 0 && f[cy*FW+cx]) begin
            hit = 1; cnt++;
          end
        end
  endfunction

  task automatic do_req(input string tag, input logic [0:FW*FH-1] f, input logic [0:B*B-1] b,
                        input int x, input int y, input int hold);
    int eh, ew, ec, lat, sh, sw;
    bit seen;
    model(f, b, x, y, eh, ew, ec);
    for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
    check({tag, ".req_ready"}, int'(req_ready), 1);
    field = f; block = b; blk_x = PW'(x); blk_y = PW'(y); req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    field = ~f; block = ~b; blk_x = ~blk_x; blk_y = ~blk_y;
    check({tag, ".busy"}, int'(req_ready), 0);
    lat = 0; seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk); lat++;
      @(negedge clk); seen = res_valid;
    end
    check({tag, ".latency"}, lat, B);
    check({tag, ".hit"}, int'(res_hit), eh);
    check({tag, ".wall"}, int'(res_wall), ew);
    check({tag, ".conflict"}, int'(res_conflict), int'(eh != 0 || ew != 0));
`ifdef CONFLICT_SCAN_COUNT_EN
    check({tag, ".count"}, int'(res_count), ec);
`endif
    sh = int'(res_hit); sw = int'(res_wall);
    for (int k = 0; k < hold; k++) begin
      field = FW*FH'($urandom()); block = B*B'($urandom()); blk_x = PW'($urandom());
      req_valid = (k == 2);
      @(posedge clk);
      @(negedge clk);
      check({tag, ".hold_valid"}, int'(res_valid), 1);
      check({tag, ".hold_hit"}, int'(res_hit), sh);
      check({tag, ".hold_wall"}, int'(res_wall), sw);
      check({tag, ".hold_ready"}, int'(req_ready), 0);
    end
    req_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, ".post_valid"}, int'(res_valid), 0);
    check({tag, ".post_conflict"}, int'(res_conflict), 0);
    check({tag, ".post_ready"}, int'(req_ready), 1);
    if (hold > 0) begin
      // The pulse during DONE must not have started a scan.
      @(negedge clk);
      check({tag, ".no_queue"}, int'(req_ready), 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [0:FW*FH-1] f_empty, f_one, f_rnd;
    logic [0:B*B-1]   t_piece, col_l, col_r, full, b_rnd;
    f_empty = '0;
    f_one = '0; f_one[24] = 1'b1;
    t_piece = 9'b111_010_000;
    col_l   = 9'b100_100_100;
    col_r   = 9'b001_001_001;
    full    = 9'b111_111_111;

    rst_n = 1'b0; req_valid = 1'b0; res_ready = 1'b0;
    field = '0; block = '0; blk_x = '0; blk_y = '0;
    repeat (3) @(negedge clk);
    check("rst.req_ready", int'(req_ready), 1);
    check("rst.res_valid", int'(res_valid), 0);
    check("rst.hit", int'(res_hit), 0);
    check("rst.wall", int'(res_wall), 0);
    check("rst.conflict", int'(res_conflict), 0);
`ifdef CONFLICT_SCAN_COUNT_EN
    check("rst.count", int'(res_count), 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    do_req("t_empty", f_empty, t_piece, 3, 0, 0);
    do_req("t_hit",   f_one,   t_piece, 3, 1, 0);
    do_req("wall_l",  f_empty, col_l,  -1, 2, 0);
    do_req("wall_r",  f_empty, col_r,   8, 2, 0);
    do_req("spawn",   f_empty, full,    3, -2, 0);
    do_req("floor",   f_empty, full,    3, 8, 0);
    do_req("zero",    f_one,   '0,      3, 1, 0);
    do_req("hold",    f_one,   t_piece, 3, 1, 5);

    // Reset while scanning row 1 aborts the request.
    field = f_one; block = t_piece; blk_x = 5'sd3; blk_y = 5'sd1; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort.req_ready", int'(req_ready), 1);
    check("abort.res_valid", int'(res_valid), 0);
    check("abort.conflict", int'(res_conflict), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort.idle_valid", int'(res_valid), 0);
    do_req("after_abort", f_one, t_piece, 3, 1, 0);

    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < FW*FH; k++) f_rnd[k] = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < B*B; k++)   b_rnd[k] = $urandom_range(0, 1) == 1;
      do_req($sformatf("rnd%0d", n), f_rnd, b_rnd,
             int'($urandom_range(0, 14)) - 3, int'($urandom_range(0, 15)) - 4, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
